fsm_step_controller: RTL

Run/pause/single-step sequencer for the board-level FSM demos. It turns the 50 MHz board clock into a one-cycle `tick` enable at a selectable rate, or one tick per press of a step button, so the demo FSMs advance visibly. The FSM datapath stays on `clk` and qualifies its state register with `tick`, replacing the free-running 1 Hz divided clock. It also carries the push-button synchronizers and debouncers for the run and step buttons.

---
 rtl/fsm_step_controller_if.sv | 20 ++
 rtl/fsm_step_controller.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fsm_step_controller_if.sv
// Button inputs and tick/status outputs of the run/pause/single-step sequencer.
interface fsm_step_controller_if;
    logic       run_btn;
    logic       step_btn;
    logic [1:0] rate_sel;
    logic       tick;
    logic       running;
    logic       heartbeat;
    logic [7:0] tick_count;

    modport master (
        output run_btn, step_btn, rate_sel,
        input  tick, running, heartbeat, tick_count
    );

    modport slave (
        input  run_btn, step_btn, rate_sel,
        output tick, running, heartbeat, tick_count
    );
endinterface

// File: rtl/fsm_step_controller.sv
// Run/pause/single-step sequencer: emits a one-cycle tick enable at a selectable
// rate in RUN, or one tick per debounced step press, for the board FSM demos.
module fsm_step_controller #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned DIV_W      = 26,
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    fsm_step_controller_if.slave  bus
);
    localparam int unsigned DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam int unsigned NBTN     = 2;
    localparam int unsigned BTN_RUN  = 0;
    localparam int unsigned BTN_STEP = 1;

    typedef enum logic [1:0] {
        S_PAUSE = 2'd0,
        S_RUN   = 2'd1,
        S_STEP  = 2'd2
    } state_t;

    logic [NBTN-1:0]  raw;
    logic [NBTN-1:0]  sync1;
    logic [NBTN-1:0]  sync2;
    logic [NBTN-1:0]  level;
    logic [NBTN-1:0]  press;
    logic [DEB_W-1:0] deb_cnt [NBTN];

    state_t           state;
    state_t           state_n;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_cnt_n;
    logic [DIV_W-1:0] tc_c;
    logic             tick_q;
    logic             tick_n;
    logic             running_q;
    logic             hb_q;
    logic             hb_n;
    logic [7:0]       count_q;
    logic [7:0]       count_n;

    assign raw = {bus.step_btn, bus.run_btn};

    // Synchronize, then accept a new level only after DEB_CYCLES consecutive disagreeing cycles.
    // The press pulse is registered alongside the accepted rising level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            press <= '0;
            for (int i = 0; i < NBTN; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < NBTN; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    deb_cnt[i] <= '0;
                    level[i]   <= sync2[i];
                    press[i]   <= sync2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // Terminal count follows rate_sel without a pipeline stage.
    always_comb tc_c = DIV_W'((CLK_HZ >> bus.rate_sel) - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_PAUSE;
            div_cnt   <= '0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            hb_q      <= 1'b0;
            count_q   <= '0;
        end else begin
            state     <= state_n;
            div_cnt   <= div_cnt_n;
            tick_q    <= tick_n;
            running_q <= (state_n == S_RUN);
            hb_q      <= hb_n;
            count_q   <= count_n;
        end
    end

    always_comb begin
        state_n   = state;
        div_cnt_n = div_cnt;
        tick_n    = 1'b0;
        hb_n      = hb_q ^ tick_q;
        count_n   = count_q + 8'(tick_q);
        unique case (state)
            S_PAUSE: begin
                div_cnt_n = '0;
                if (press[BTN_RUN]) begin
                    state_n = S_RUN;
                end else if (press[BTN_STEP]) begin
                    state_n = S_STEP;
                    tick_n  = 1'b1;
                end
            end
            S_RUN: begin
                // >= so a mid-count rate increase fires promptly instead of wrapping.
                if (press[BTN_RUN]) begin
                    state_n   = S_PAUSE;
                    div_cnt_n = '0;
                end else if (div_cnt >= tc_c) begin
                    div_cnt_n = '0;
                    tick_n    = 1'b1;
                end else begin
                    div_cnt_n = div_cnt + DIV_W'(1);
                end
            end
            S_STEP:  state_n = S_PAUSE;
            default: state_n = S_PAUSE;
        endcase
    end

    assign bus.tick       = tick_q;
    assign bus.running    = running_q;
    assign bus.heartbeat  = hb_q;
    assign bus.tick_count = count_q;
endmodule
